// File: rtl/note_pattern_gen_if.sv
// Pixel-path bundle between the note recogniser / raster counter and the pattern generator.
// Latency: none, wires only.
// Backpressure: none; every signal is sampled or presented each clock.
interface note_pattern_gen_if #(
    parameter int w_x     = 10,
    parameter int w_y     = 9,
    parameter int w_red   = 4,
    parameter int w_green = 4,
    parameter int w_blue  = 4
) ();

    // Note recogniser strobe and cursor controls
    logic               note_vld;
    logic [3:0]         note_idx;
    logic               dir_up;
    logic               dir_down;
    logic               freeze;

    // Raster position of the pixel being generated
    logic [w_x-1:0]     x;
    logic [w_y-1:0]     y;

    // Generated pixel and status
    logic [w_red-1:0]   red;
    logic [w_green-1:0] green;
    logic [w_blue-1:0]  blue;
    logic [1:0]         mode;
    logic               tick;

    // Driver side: recogniser, raster counter and display sink
    modport master (
        output note_vld, note_idx, dir_up, dir_down, freeze, x, y,
        input  red, green, blue, mode, tick
    );

    // Pattern generator side
    modport slave (
        input  note_vld, note_idx, dir_up, dir_down, freeze, x, y,
        output red, green, blue, mode, tick
    );

endinterface

// File: rtl/note_pattern_gen.sv
// Turns recognised notes into animated full-screen patterns driven by a bouncing/steerable cursor.
// Latency: RGB registered one clock after x/y; mode/cursor updates show on the next computed pixel.
// Backpressure: none; note strobes and pixel coordinates are consumed every clock.
module note_pattern_gen #(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_red         = 4,
    parameter int w_green       = 4,
    parameter int w_blue        = 4,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int w_tick        = 20,
    parameter int step          = 1,
    parameter int hold_ticks    = 64
) (
    input  logic               clk,
    input  logic               rst,
    note_pattern_gen_if.slave  bus
);

    // Pattern arithmetic width: wide enough for |dx|*|dy| and coordinate sums without overflow
    localparam int w_max  = (w_x > w_y) ? w_x : w_y;
    localparam int w_p    = 2 * w_max + 1;
    localparam int w_hold = $clog2(hold_ticks + 1);

    localparam logic [w_x-1:0]    px_last   = w_x'(screen_width - 1);
    localparam logic [w_y-1:0]    py_last   = w_y'(screen_height - 1);
    localparam logic [w_y-1:0]    py_home   = w_y'(screen_height / 2);
    localparam logic [w_x-1:0]    step_x    = w_x'(step);
    localparam logic [w_y-1:0]    step_y    = w_y'(step);
    localparam logic [w_hold-1:0] hold_last = w_hold'(hold_ticks - 1);
    localparam logic [w_p-1:0]    area_lim  = w_p'(screen_width * screen_height / 16);

    localparam logic [1:0] mode_dflt = 2'd3;

    // Motion divider
    logic [w_tick-1:0]  tcnt_q, tcnt_d;
    logic               tick;

    // Cursor state; dx_q = 1 means moving right
    logic [w_x-1:0]     px_q, px_d;
    logic               dx_q, dx_d;
    logic [w_y-1:0]     py_q, py_d;
    logic [w_x:0]       px_inc;
    logic [w_y:0]       py_inc;

    // Mode state and timeout counter
    logic [1:0]         mode_q, mode_d;
    logic [w_hold-1:0]  hold_q, hold_d;
    logic               note_ok;
    logic [1:0]         note_mode;

    // Pixel pipeline
    logic [w_red-1:0]   red_q, red_d;
    logic [w_green-1:0] green_q, green_d;
    logic [w_blue-1:0]  blue_q, blue_d;
    logic [w_p-1:0]     xe, ye, pxe, pye;
    logic [w_p-1:0]     sum_xy, dif_xy, sum_p, adx, ady, prod;

    // State register: all flops, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q  <= '0;
            px_q    <= '0;
            dx_q    <= 1'b1;
            py_q    <= py_home;
            mode_q  <= mode_dflt;
            hold_q  <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            px_q    <= px_d;
            dx_q    <= dx_d;
            py_q    <= py_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    // Free-running divider; tick fires on the all-ones count so the first one lands 2**w_tick-1 clocks out of reset
    always_comb begin
        tcnt_d = tcnt_q + w_tick'(1);
        tick   = &tcnt_q;
    end

    // Horizontal cursor bounces between the screen edges, clamping instead of wrapping
    always_comb begin
        px_d   = px_q;
        dx_d   = dx_q;
        px_inc = {1'b0, px_q} + {1'b0, step_x};
        if (tick && !bus.freeze) begin
            if (dx_q) begin
                if (px_inc >= {1'b0, px_last}) begin
                    px_d = px_last;
                    dx_d = 1'b0;
                end else begin
                    px_d = px_inc[w_x-1:0];
                end
            end else begin
                if (px_q <= step_x) begin
                    px_d = '0;
                    dx_d = 1'b1;
                end else begin
                    px_d = px_q - step_x;
                end
            end
        end
    end

    // Vertical cursor steered by dir_up/dir_down, saturating at top and bottom; conflicting requests cancel
    always_comb begin
        py_d   = py_q;
        py_inc = {1'b0, py_q} + {1'b0, step_y};
        if (tick && !bus.freeze) begin
            if (bus.dir_up && !bus.dir_down) begin
                if (py_q <= step_y) begin
                    py_d = '0;
                end else begin
                    py_d = py_q - step_y;
                end
            end else if (bus.dir_down && !bus.dir_up) begin
                if (py_inc >= {1'b0, py_last}) begin
                    py_d = py_last;
                end else begin
                    py_d = py_inc[w_y-1:0];
                end
            end
        end
    end

    // Mode next state: timeout back to the default pattern, with a valid note taking priority.
    // The counter clears on the tick that would reach hold_ticks, so it never sits at the limit.
    always_comb begin
        mode_d    = mode_q;
        hold_d    = hold_q;
        note_ok   = bus.note_vld && (bus.note_idx <= 4'd11);
        note_mode = 2'(bus.note_idx % 4'd3);
        if (tick && (mode_q != mode_dflt)) begin
            if (hold_q >= hold_last) begin
                mode_d = mode_dflt;
                hold_d = '0;
            end else begin
                hold_d = hold_q + w_hold'(1);
            end
        end
        if (note_ok) begin
            mode_d = note_mode;
            hold_d = '0;
        end
    end

    // Pattern output: pixel colour from the current raster position, cursor and mode
    always_comb begin
        xe      = w_p'(bus.x);
        ye      = w_p'(bus.y);
        pxe     = w_p'(px_q);
        pye     = w_p'(py_q);
        sum_xy  = xe + ye;
        dif_xy  = xe - ye;
        sum_p   = pxe + pye;
        adx     = (xe >= pxe) ? (xe - pxe) : (pxe - xe);
        ady     = (ye >= pye) ? (ye - pye) : (pye - ye);
        prod    = adx * ady;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        case (mode_q)
            2'd0: begin
                // Gradient to the left of the cursor
                if (xe < pxe) begin
                    red_d   = w_red'(sum_xy >> 3);
                    green_d = w_green'(dif_xy >> 3);
                    blue_d  = w_blue'(xe >> 3);
                end
            end
            2'd1: begin
                // Hyperbolic cross centred on the cursor
                if (prod < area_lim) begin
                    red_d   = w_red'(xe >> 3);
                    green_d = w_green'(ye >> 3);
                    blue_d  = '1;
                end
            end
            2'd2: begin
                // Diagonal wedge above-left of the cursor
                if (sum_xy < sum_p) begin
                    red_d   = '1;
                    green_d = '1;
                    blue_d  = w_blue'(sum_xy >> 3);
                end
            end
            default: begin
                // Default quadrants split at the cursor
                if (xe < pxe) begin
                    red_d = '1;
                end else begin
                    blue_d = '1;
                end
                if (ye < pye) begin
                    green_d = '1;
                end
            end
        endcase
    end

    assign bus.red   = red_q;
    assign bus.green = green_q;
    assign bus.blue  = blue_q;
    assign bus.mode  = mode_q;
    assign bus.tick  = tick;

endmodule

// File: tb/tb_note_pattern_gen.sv
// Self-checking bench for note_pattern_gen with a fast motion tick and short mode timeout.
// Latency: expected pixels queued when x/y are driven, popped one clock later.
// Backpressure: not applicable.
module tb_note_pattern_gen;

    localparam int SW   = 640;
    localparam int SH   = 480;
    localparam int STEP = 1;
    localparam int HOLD = 4;
    localparam int TMAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    note_pattern_gen_if #(.w_x(10), .w_y(9), .w_red(4), .w_green(4), .w_blue(4)) bus_if ();

    note_pattern_gen #(
        .screen_width(SW), .screen_height(SH),
        .w_red(4), .w_green(4), .w_blue(4),
        .w_tick(2), .step(STEP), .hold_ticks(HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    int m_tcnt, m_px, m_dx, m_py, m_mode, m_hold;
    logic [11:0] exp_q[$];

    function automatic logic [11:0] pix(int x, int y, int px, int py, int mode);
        int r, g, b, ax, ay;
        r = 0; g = 0; b = 0;
        ax = (x >= px) ? x - px : px - x;
        ay = (y >= py) ? y - py : py - y;
        case (mode)
            0: if (x < px) begin
                r = ((x + y) >> 3) & 15;
                g = (((x - y) & 32'h001F_FFFF) >> 3) & 15;
                b = (x >> 3) & 15;
            end
            1: if (ax * ay < SW * SH / 16) begin
                r = (x >> 3) & 15;
                g = (y >> 3) & 15;
                b = 15;
            end
            2: if (x + y < px + py) begin
                r = 15;
                g = 15;
                b = ((x + y) >> 3) & 15;
            end
            default: begin
                if (x < px) r = 15; else b = 15;
                if (y < py) g = 15;
            end
        endcase
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    // Advance DUT and reference one clock; queue the pixel expected from the inputs just applied
    task automatic cyc();
        int n_tcnt, n_px, n_dx, n_py, n_mode, n_hold;
        bit tk;
        tk = (m_tcnt == TMAX);
        if (rst) begin
            exp_q.push_back(12'h000);
            n_tcnt = 0; n_px = 0; n_dx = 1; n_py = SH / 2; n_mode = 3; n_hold = 0;
        end else begin
            exp_q.push_back(pix(int'(bus_if.x), int'(bus_if.y), m_px, m_py, m_mode));
            n_tcnt = (m_tcnt + 1) % (TMAX + 1);
            n_px = m_px; n_dx = m_dx; n_py = m_py; n_mode = m_mode; n_hold = m_hold;
            if (tk && !bus_if.freeze) begin
                if (m_dx > 0) begin
                    if (m_px + STEP >= SW - 1) begin n_px = SW - 1; n_dx = -1; end
                    else n_px = m_px + STEP;
                end else begin
                    if (m_px <= STEP) begin n_px = 0; n_dx = 1; end
                    else n_px = m_px - STEP;
                end
                if (bus_if.dir_up && !bus_if.dir_down)
                    n_py = (m_py - STEP < 0) ? 0 : m_py - STEP;
                else if (bus_if.dir_down && !bus_if.dir_up)
                    n_py = (m_py + STEP > SH - 1) ? SH - 1 : m_py + STEP;
            end
            if (tk && m_mode != 3) begin
                if (m_hold + 1 >= HOLD) begin n_mode = 3; n_hold = 0; end
                else n_hold = m_hold + 1;
            end
            if (bus_if.note_vld && bus_if.note_idx <= 4'd11) begin
                n_mode = int'(bus_if.note_idx) % 3;
                n_hold = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        m_tcnt = n_tcnt; m_px = n_px; m_dx = n_dx; m_py = n_py; m_mode = n_mode; m_hold = n_hold;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            e = exp_q.pop_front();
            vectors++;
            if ({bus_if.red, bus_if.green, bus_if.blue} !== e) begin
                miscompares++;
                $display("FAIL reset_rgb got=%h want=%h", {bus_if.red, bus_if.green, bus_if.blue}, e);
            end
        end
        vectors++;
        if (bus_if.mode !== 2'd3) begin miscompares++; $display("FAIL reset_mode got=%0d want=3", bus_if.mode); end
        vectors++;
        if (bus_if.tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got=%b want=0", bus_if.tick); end
        vectors++;
        if (dut.px_q !== 10'd0 || dut.dx_q !== 1'b1 || dut.py_q !== 9'd240) begin
            miscompares++;
            $display("FAIL reset_cursor got px=%0d dx=%b py=%0d want px=0 dx=1 py=240", dut.px_q, dut.dx_q, dut.py_q);
        end
        rst = 1'b0;
        bus_if.x = 10'd0;
        bus_if.y = 9'd300;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            e = exp_q.pop_front();
            vectors++;
            if ({bus_if.red, bus_if.green, bus_if.blue} !== e) begin
                miscompares++;
                $display("FAIL post_reset_rgb cyc=%0d got=%h want=%h", i, {bus_if.red, bus_if.green, bus_if.blue}, e);
            end
            if (i == 1) begin
                vectors++;
                if ({bus_if.red, bus_if.green, bus_if.blue} !== 12'h00F) begin
                    miscompares++;
                    $display("FAIL first_pixel got=%h want=00f", {bus_if.red, bus_if.green, bus_if.blue});
                end
            end
            vectors++;
            if (bus_if.tick !== (i == 3)) begin
                miscompares++;
                $display("FAIL first_tick cyc=%0d got=%b want=%b", i, bus_if.tick, (i == 3));
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] e;
        bit seen_max = 0;
        bit done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            bus_if.x = 10'($urandom_range(0, SW - 1));
            bus_if.y = 9'($urandom_range(0, SH - 1));
            cyc();
            e = exp_q.pop_front();
            vectors++;
            if ({bus_if.red, bus_if.green, bus_if.blue} !== e) begin
                miscompares++;
                $display("FAIL bounce_rgb got=%h want=%h", {bus_if.red, bus_if.green, bus_if.blue}, e);
            end
            vectors++;
            if (dut.px_q !== 10'(m_px) || dut.dx_q !== (m_dx > 0)) begin
                miscompares++;
                $display("FAIL bounce_px got px=%0d dx=%b want px=%0d dx=%b", dut.px_q, dut.dx_q, m_px, (m_dx > 0));
            end
            vectors++;
            if (dut.px_q > 10'd639) begin
                miscompares++;
                $display("FAIL bounce_range got px=%0d want <=639", dut.px_q);
            end
            if (m_px == SW - 1) seen_max = 1;
            if (seen_max && m_px == SW - 2) done = 1;
        end
        vectors++;
        if (!done) begin miscompares++; $display("FAIL bounce_timeout got no 639->638 turn want turn"); end
    endtask

    task automatic test_freeze_reset();
        logic [11:0] e;
        int s_px, s_py, s_dx, nt;
        s_px = m_px; s_py = m_py; s_dx = m_dx; nt = 0;
        bus_if.freeze = 1'b1;
        bus_if.dir_down = 1'b1;
        for (int i = 0; i < 80 && nt < 10; i++) begin
            if (bus_if.tick) nt++;
            vectors++;
            if (bus_if.tick !== (m_tcnt == TMAX)) begin
                miscompares++;
                $display("FAIL freeze_tick got=%b want=%b", bus_if.tick, (m_tcnt == TMAX));
            end
            cyc();
            e = exp_q.pop_front();
            vectors++;
            if ({bus_if.red, bus_if.green, bus_if.blue} !== e) begin
                miscompares++;
                $display("FAIL freeze_rgb got=%h want=%h", {bus_if.red, bus_if.green, bus_if.blue}, e);
            end
            vectors++;
            if (dut.px_q !== 10'(s_px) || dut.py_q !== 9'(s_py) || dut.dx_q !== (s_dx > 0)) begin
                miscompares++;
                $display("FAIL freeze_hold got px=%0d py=%0d dx=%b want px=%0d py=%0d dx=%b",
                         dut.px_q, dut.py_q, dut.dx_q, s_px, s_py, (s_dx > 0));
            end
        end
        vectors++;
        if (nt != 10) begin miscompares++; $display("FAIL freeze_ticks got=%0d want=10", nt); end
        bus_if.freeze = 1'b0;
        bus_if.dir_down = 1'b0;
        vectors++;
        if (dut.dx_q !== 1'b0) begin miscompares++; $display("FAIL mid_bounce_dx got=%b want=0", dut.dx_q); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if ({bus_if.red, bus_if.green, bus_if.blue} !== e || e !== 12'h000) begin
            miscompares++;
            $display("FAIL midreset_rgb got=%h want=000", {bus_if.red, bus_if.green, bus_if.blue});
        end
        vectors++;
        if (dut.px_q !== 10'd0 || dut.dx_q !== 1'b1 || dut.py_q !== 9'd240 || bus_if.mode !== 2'd3) begin
            miscompares++;
            $display("FAIL midreset_state got px=%0d dx=%b py=%0d mode=%0d want 0 1 240 3",
                     dut.px_q, dut.dx_q, dut.py_q, bus_if.mode);
        end
    endtask

    task automatic test_vertical();
        // {dir_down, dir_up, ticks, final py}
        int tbl[5][4] = '{'{1, 0, 300, 479}, '{0, 1, 500, 0}, '{1, 0, 50, 50},
                          '{1, 1, 20, 50}, '{0, 0, 20, 50}};
        logic [11:0] e;
        int nt;
        for (int p = 0; p < 5; p++) begin
            bus_if.dir_down = tbl[p][0][0];
            bus_if.dir_up   = tbl[p][1][0];
            nt = 0;
            for (int i = 0; i < 4 * tbl[p][2] + 8 && nt < tbl[p][2]; i++) begin
                if (m_tcnt == TMAX) nt++;
                bus_if.x = 10'($urandom_range(0, SW - 1));
                bus_if.y = 9'($urandom_range(0, SH - 1));
                cyc();
                e = exp_q.pop_front();
                vectors++;
                if ({bus_if.red, bus_if.green, bus_if.blue} !== e || dut.py_q !== 9'(m_py)) begin
                    miscompares++;
                    $display("FAIL vert_step phase=%0d got rgb=%h py=%0d want rgb=%h py=%0d",
                             p, {bus_if.red, bus_if.green, bus_if.blue}, dut.py_q, e, m_py);
                end
            end
            vectors++;
            if (dut.py_q !== 9'(tbl[p][3])) begin
                miscompares++;
                $display("FAIL vert_final phase=%0d got=%0d want=%0d", p, dut.py_q, tbl[p][3]);
            end
        end
        bus_if.dir_down = 1'b0;
        bus_if.dir_up   = 1'b0;
    endtask

    task automatic test_note();
        logic [11:0] e;
        for (int k = 0; k < 12; k++) begin
            bus_if.note_vld = 1'b1;
            bus_if.note_idx = 4'(k);
            cyc();
            bus_if.note_vld = 1'b0;
            void'(exp_q.pop_front());
            vectors++;
            if (bus_if.mode !== 2'(k % 3) || dut.hold_q !== '0) begin
                miscompares++;
                $display("FAIL note_mode idx=%0d got mode=%0d hold=%0d want mode=%0d hold=0", k, bus_if.mode, dut.hold_q, k % 3);
            end
        end
        bus_if.note_vld = 1'b1;
        bus_if.note_idx = 4'd7;
        cyc();
        bus_if.note_vld = 1'b0;
        void'(exp_q.pop_front());
        vectors++;
        if (bus_if.mode !== 2'd1) begin miscompares++; $display("FAIL note7 got=%0d want=1", bus_if.mode); end
        bus_if.x = 10'(m_px);
        bus_if.y = 9'(m_py);
        cyc();
        e = exp_q.pop_front();
        vectors++;
        if ({bus_if.red, bus_if.green, bus_if.blue} !== e || bus_if.blue !== 4'hF) begin
            miscompares++;
            $display("FAIL cross_centre got=%h want=%h", {bus_if.red, bus_if.green, bus_if.blue}, e);
        end
        for (int k = 12; k < 16; k++) begin
            bus_if.note_vld = 1'b1;
            bus_if.note_idx = 4'(k);
            cyc();
            bus_if.note_vld = 1'b0;
            void'(exp_q.pop_front());
            vectors++;
            if (bus_if.mode !== 2'd1 || dut.hold_q !== 3'(m_hold)) begin
                miscompares++;
                $display("FAIL bad_note idx=%0d got mode=%0d hold=%0d want mode=1 hold=%0d", k, bus_if.mode, dut.hold_q, m_hold);
            end
        end
    endtask

    task automatic test_timeout();
        int nt;
        bit hit;
        bus_if.note_vld = 1'b1;
        bus_if.note_idx = 4'd5;
        cyc();
        bus_if.note_vld = 1'b0;
        void'(exp_q.pop_front());
        vectors++;
        if (bus_if.mode !== 2'd2) begin miscompares++; $display("FAIL timeout_start got=%0d want=2", bus_if.mode); end
        nt = 0;
        for (int i = 0; i < 40 && bus_if.mode != 2'd3; i++) begin
            if (bus_if.tick) nt++;
            cyc();
            void'(exp_q.pop_front());
            vectors++;
            if (bus_if.mode !== 2'(m_mode)) begin
                miscompares++;
                $display("FAIL timeout_mode got=%0d want=%0d", bus_if.mode, m_mode);
            end
        end
        vectors++;
        if (bus_if.mode !== 2'd3 || nt != 4) begin
            miscompares++;
            $display("FAIL timeout_ticks got mode=%0d ticks=%0d want mode=3 ticks=4", bus_if.mode, nt);
        end
        // Re-arm, then land a note exactly on the expiring tick
        bus_if.note_vld = 1'b1;
        bus_if.note_idx = 4'd8;
        cyc();
        bus_if.note_vld = 1'b0;
        void'(exp_q.pop_front());
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_tcnt == TMAX && m_hold == HOLD - 1) hit = 1;
            else begin cyc(); void'(exp_q.pop_front()); end
        end
        vectors++;
        if (!hit || dut.hold_q !== 3'd3 || bus_if.tick !== 1'b1) begin
            miscompares++;
            $display("FAIL coincide_setup got hold=%0d tick=%b want hold=3 tick=1", dut.hold_q, bus_if.tick);
        end
        bus_if.note_vld = 1'b1;
        bus_if.note_idx = 4'd3;
        cyc();
        bus_if.note_vld = 1'b0;
        void'(exp_q.pop_front());
        vectors++;
        if (bus_if.mode !== 2'd0 || dut.hold_q !== 3'd0) begin
            miscompares++;
            $display("FAIL coincide_note got mode=%0d hold=%0d want mode=0 hold=0", bus_if.mode, dut.hold_q);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_if.note_vld = 1'b0;
        bus_if.note_idx = 4'd0;
        bus_if.dir_up   = 1'b0;
        bus_if.dir_down = 1'b0;
        bus_if.freeze   = 1'b0;
        bus_if.x        = 10'd0;
        bus_if.y        = 9'd0;
        m_tcnt = 0; m_px = 0; m_dx = 1; m_py = SH / 2; m_mode = 3; m_hold = 0;
        test_reset();
        test_bounce();
        test_freeze_reset();
        test_vertical();
        test_note();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got no completion want finish within 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
